sd_deser_pack: RTL and testbench



---
 rtl/sd_deser_pack_if.sv | 29 ++
 rtl/sd_deser_pack.sv | 112 +++++++++++
 tb/tb_sd_deser_pack.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_deser_pack_if.sv
// Segment-in / word-out bundle for sd_deser_pack. The slave modport is the
// deserializer's view; master is the view of whatever surrounds it.
interface sd_deser_pack_if #(
  parameter int PARA_WIDTH = 64,
  parameter int SER_WIDTH  = 8
);
  localparam int NUM_SEG = (PARA_WIDTH + SER_WIDTH - 1) / SER_WIDTH;
  localparam int CNT_SZ  = $clog2(NUM_SEG + 1);

  logic [SER_WIDTH-1:0]  c_data;
  logic                  c_ef;
  logic                  c_srdy;
  logic                  c_drdy;
  logic [PARA_WIDTH-1:0] p_data;
  logic [CNT_SZ-1:0]     p_cnt;
  logic                  p_err;
  logic                  p_srdy;
  logic                  p_drdy;

  modport slave (
    input  c_data, c_ef, c_srdy, p_drdy,
    output c_drdy, p_data, p_cnt, p_err, p_srdy
  );

  modport master (
    output c_data, c_ef, c_srdy, p_drdy,
    input  c_drdy, p_data, p_cnt, p_err, p_srdy
  );
endinterface

// File: rtl/sd_deser_pack.sv
// Packet-aware deserializer: packs SER_WIDTH segments into a PARA_WIDTH word.
// Define SDLIB_DESER_STRICT_EN to flag and drop overlong packets.
module sd_deser_pack #(
  parameter int PARA_WIDTH = 64,
  parameter int SER_WIDTH  = 8
) (
  input  logic           clk,
  input  logic           reset,
  sd_deser_pack_if.slave bus
);
  localparam int NUM_SEG = (PARA_WIDTH + SER_WIDTH - 1) / SER_WIDTH;
  localparam int CNT_SZ  = $clog2(NUM_SEG + 1);
  localparam int ACC_W   = NUM_SEG * SER_WIDTH;

  typedef enum logic {ST_ACC, ST_DROP} state_t;

  state_t                state_reg, state_next;
  logic [ACC_W-1:0]      acc_reg;
  logic [ACC_W-1:0]      merged;
  logic [CNT_SZ-1:0]     seg_num_reg;
  logic [PARA_WIDTH-1:0] p_data_reg;
  logic [CNT_SZ-1:0]     p_cnt_reg;
  logic                  p_err_reg;
  logic                  p_srdy_reg;
  logic                  last_seg;
  logic                  completing;
  logic                  overflow;
  logic                  c_drdy_int;
  logic                  load;
  logic                  advance;

  // Accumulator with the incoming segment dropped into its slot.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SEG; gi++) begin : g_seg
      assign merged[gi*SER_WIDTH +: SER_WIDTH] =
        (seg_num_reg == CNT_SZ'(gi)) ? bus.c_data : acc_reg[gi*SER_WIDTH +: SER_WIDTH];
    end
  endgenerate

  assign last_seg   = (seg_num_reg == CNT_SZ'(NUM_SEG - 1));
  assign completing = bus.c_ef | last_seg;

`ifdef SDLIB_DESER_STRICT_EN
  assign overflow = last_seg & ~bus.c_ef;
`else
  assign overflow = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_ACC;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_ACC:  if (load && overflow) state_next = ST_DROP;
      ST_DROP: if (bus.c_srdy && bus.c_ef) state_next = ST_ACC;
      default: state_next = ST_ACC;
    endcase
  end

  // Only a completing beat can be stalled, and only by an unconsumed word.
  always_comb begin
    c_drdy_int = 1'b1;
    load       = 1'b0;
    advance    = 1'b0;
    case (state_reg)
      ST_ACC: begin
        c_drdy_int = ~completing | ~p_srdy_reg | bus.p_drdy;
        load       = bus.c_srdy & c_drdy_int & completing;
        advance    = bus.c_srdy & c_drdy_int & ~completing;
      end
      default: c_drdy_int = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg     <= '0;
      seg_num_reg <= '0;
      p_data_reg  <= '0;
      p_cnt_reg   <= '0;
      p_err_reg   <= 1'b0;
      p_srdy_reg  <= 1'b0;
    end else begin
      if (load) begin
        acc_reg     <= '0;
        seg_num_reg <= '0;
      end else if (advance) begin
        acc_reg     <= merged;
        seg_num_reg <= seg_num_reg + CNT_SZ'(1);
      end

      if (load) begin
        p_data_reg <= merged[PARA_WIDTH-1:0];
        p_cnt_reg  <= seg_num_reg + CNT_SZ'(1);
        p_err_reg  <= overflow;
        p_srdy_reg <= 1'b1;
      end else if (bus.p_drdy) begin
        p_srdy_reg <= 1'b0;
      end
    end
  end

  assign bus.c_drdy = c_drdy_int;
  assign bus.p_data = p_data_reg;
  assign bus.p_cnt  = p_cnt_reg;
  assign bus.p_err  = p_err_reg;
  assign bus.p_srdy = p_srdy_reg;
endmodule

// File: tb/tb_sd_deser_pack.sv
// Bench for sd_deser_pack at PARA_WIDTH=20, SER_WIDTH=8: directed scenarios
// plus a randomized run against a segment-list reference model.
module tb_sd_deser_pack;
  localparam int PW = 20;
  localparam int SW = 8;
  localparam int NS = 3;
`ifdef SDLIB_DESER_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sd_deser_pack_if #(.PARA_WIDTH(PW), .SER_WIDTH(SW)) bus ();

  sd_deser_pack #(.PARA_WIDTH(PW), .SER_WIDTH(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Present one beat and hold it until accepted; ok=0 if it never is.
  task automatic beat(input logic [7:0] d, input logic ef, output bit ok);
    logic rdy;
    ok = 1'b0;
    bus.c_data = d;
    bus.c_ef   = ef;
    bus.c_srdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #4 rdy = bus.c_drdy;
      @(posedge clk); #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    bus.c_srdy = 1'b0;
    bus.c_ef   = 1'b0;
    $display("beat data=%02h ef=%0b accepted=%0b", d, ef, ok);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.c_srdy = 0; bus.c_ef = 0; bus.c_data = 0; bus.p_drdy = 0;
    reset = 1;
    tick(); tick();
    checks++; if (bus.p_srdy !== 1'b0) begin errors++; $display("FAIL reset_srdy got=%0b want=0", bus.p_srdy); end
    checks++; if (bus.p_data !== 20'h0) begin errors++; $display("FAIL reset_data got=%05h want=00000", bus.p_data); end
    checks++; if (bus.p_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got=%0d want=0", bus.p_cnt); end
    checks++; if (bus.p_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b want=0", bus.p_err); end
    checks++; if (bus.c_drdy !== 1'b1) begin errors++; $display("FAIL reset_drdy got=%0b want=1", bus.c_drdy); end
    reset = 0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_full_word();
    bit ok, all_ok;
    bus.p_drdy = 1;
    all_ok = 1;
    beat(8'hA1, 0, ok); all_ok &= ok;
    beat(8'hB2, 0, ok); all_ok &= ok;
    beat(8'hC3, 1, ok); all_ok &= ok;
    checks++; if (!all_ok) begin errors++; $display("FAIL full_accept got=0 want=1"); end
    checks++; if (bus.p_srdy !== 1'b1) begin errors++; $display("FAIL full_srdy got=%0b want=1", bus.p_srdy); end
    checks++; if (bus.p_data !== 20'h3B2A1) begin errors++; $display("FAIL full_data got=%05h want=3b2a1", bus.p_data); end
    checks++; if (bus.p_cnt !== 2'd3) begin errors++; $display("FAIL full_cnt got=%0d want=3", bus.p_cnt); end
    checks++; if (bus.p_err !== 1'b0) begin errors++; $display("FAIL full_err got=%0b want=0", bus.p_err); end
    tick();
    checks++; if (bus.p_srdy !== 1'b0) begin errors++; $display("FAIL full_srdy_pulse got=%0b want=0", bus.p_srdy); end
    $display("test_full_word done");
  endtask

  task automatic test_short_word();
    bit ok, all_ok;
    bus.p_drdy = 1;
    all_ok = 1;
    beat(8'h11, 0, ok); all_ok &= ok;
    beat(8'h22, 1, ok); all_ok &= ok;
    checks++; if (bus.p_data !== 20'h02211) begin errors++; $display("FAIL short_data got=%05h want=02211", bus.p_data); end
    checks++; if (bus.p_cnt !== 2'd2) begin errors++; $display("FAIL short_cnt got=%0d want=2", bus.p_cnt); end
    beat(8'h33, 1, ok); all_ok &= ok;
    checks++; if (!all_ok) begin errors++; $display("FAIL short_accept got=0 want=1"); end
    checks++; if (bus.p_data !== 20'h00033) begin errors++; $display("FAIL short_residue got=%05h want=00033", bus.p_data); end
    checks++; if (bus.p_cnt !== 2'd1) begin errors++; $display("FAIL short_residue_cnt got=%0d want=1", bus.p_cnt); end
    tick();
    $display("test_short_word done");
  endtask

  task automatic test_back_pressure();
    bit ok, all_ok;
    bus.p_drdy = 0;
    all_ok = 1;
    beat(8'h44, 1, ok); all_ok &= ok;
    beat(8'h01, 0, ok); all_ok &= ok;
    beat(8'h02, 0, ok); all_ok &= ok;
    checks++; if (!all_ok) begin errors++; $display("FAIL bp_accept got=0 want=1"); end
    bus.c_data = 8'h03; bus.c_ef = 1; bus.c_srdy = 1;
    #4;
    checks++; if (bus.c_drdy !== 1'b0) begin errors++; $display("FAIL bp_stall got=%0b want=0", bus.c_drdy); end
    @(posedge clk); #1;
    checks++; if (bus.p_data !== 20'h00044 || bus.p_cnt !== 2'd1 || bus.p_srdy !== 1'b1)
      begin errors++; $display("FAIL bp_hold got=%05h/%0d/%0b want=00044/1/1", bus.p_data, bus.p_cnt, bus.p_srdy); end
    bus.p_drdy = 1;
    #4;
    checks++; if (bus.c_drdy !== 1'b1) begin errors++; $display("FAIL bp_release got=%0b want=1", bus.c_drdy); end
    @(posedge clk); #1;
    bus.c_srdy = 0; bus.c_ef = 0;
    checks++; if (bus.p_srdy !== 1'b1 || bus.p_data !== 20'h30201 || bus.p_cnt !== 2'd3)
      begin errors++; $display("FAIL bp_swap got=%05h/%0d/%0b want=30201/3/1", bus.p_data, bus.p_cnt, bus.p_srdy); end
    tick();
    checks++; if (bus.p_srdy !== 1'b0) begin errors++; $display("FAIL bp_drain got=%0b want=0", bus.p_srdy); end
    $display("test_back_pressure done");
  endtask

  task automatic test_overflow();
    bit ok, all_ok;
    bus.p_drdy = 1;
    all_ok = 1;
    beat(8'h01, 0, ok); all_ok &= ok;
    beat(8'h02, 0, ok); all_ok &= ok;
    beat(8'h03, 0, ok); all_ok &= ok;
    checks++; if (bus.p_data !== 20'h30201 || bus.p_cnt !== 2'd3 || bus.p_err !== STRICT)
      begin errors++; $display("FAIL ovf_word got=%05h/%0d/%0b want=30201/3/%0b", bus.p_data, bus.p_cnt, bus.p_err, STRICT); end
    beat(8'h04, 1, ok); all_ok &= ok;
    if (STRICT) begin
      checks++; if (bus.p_srdy !== 1'b0) begin errors++; $display("FAIL ovf_drop got=%0b want=0", bus.p_srdy); end
      beat(8'h05, 1, ok); all_ok &= ok;
      checks++; if (bus.p_srdy !== 1'b1 || bus.p_data !== 20'h00005 || bus.p_cnt !== 2'd1 || bus.p_err !== 1'b0)
        begin errors++; $display("FAIL ovf_next got=%05h/%0d/%0b want=00005/1/0", bus.p_data, bus.p_cnt, bus.p_err); end
    end else begin
      checks++; if (bus.p_srdy !== 1'b1 || bus.p_data !== 20'h00004 || bus.p_cnt !== 2'd1 || bus.p_err !== 1'b0)
        begin errors++; $display("FAIL ovf_next got=%05h/%0d/%0b want=00004/1/0", bus.p_data, bus.p_cnt, bus.p_err); end
    end
    checks++; if (!all_ok) begin errors++; $display("FAIL ovf_accept got=0 want=1"); end
    tick();
    $display("test_overflow done");
  endtask

  task automatic test_reset_mid_word();
    bit ok, all_ok;
    bus.p_drdy = 0;
    all_ok = 1;
    beat(8'h66, 1, ok); all_ok &= ok;
    beat(8'hAA, 0, ok); all_ok &= ok;
    reset = 1;
    tick();
    reset = 0;
    checks++; if (bus.p_srdy !== 1'b0 || bus.p_data !== 20'h0 || bus.p_cnt !== 2'd0 || bus.p_err !== 1'b0)
      begin errors++; $display("FAIL rstmid_clear got=%05h/%0d/%0b/%0b want=00000/0/0/0", bus.p_data, bus.p_cnt, bus.p_err, bus.p_srdy); end
    bus.p_drdy = 1;
    beat(8'h55, 1, ok); all_ok &= ok;
    checks++; if (!all_ok) begin errors++; $display("FAIL rstmid_accept got=0 want=1"); end
    checks++; if (bus.p_data !== 20'h00055 || bus.p_cnt !== 2'd1)
      begin errors++; $display("FAIL rstmid_word got=%05h/%0d want=00055/1", bus.p_data, bus.p_cnt); end
    tick();
    $display("test_reset_mid_word done");
  endtask

  // Model: list of accepted segments; a word is their little-endian
  // concatenation truncated to PW bits, emitted on c_ef or when NS are held.
  task automatic test_random();
    logic [7:0]  segs[$];
    logic [23:0] exp_q[$];
    logic [23:0] w, e;
    bit          drop, m_srdy, load, completes, exp_drdy, acc;
    int          words;
    drop = 0; m_srdy = 0; words = 0;
    bus.c_srdy = 0; bus.p_drdy = 0;
    reset = 1; tick(); reset = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.c_srdy = ($urandom_range(0, 3) != 0);
      bus.c_data = 8'($urandom);
      bus.c_ef   = ($urandom_range(0, 3) == 0);
      bus.p_drdy = ($urandom_range(0, 2) != 0);
      #4;
      completes = !drop && (bus.c_ef || segs.size() == NS - 1);
      exp_drdy  = drop || !completes || !m_srdy || bus.p_drdy;
      checks++; if (bus.c_drdy !== exp_drdy) begin errors++; $display("FAIL rnd_drdy cyc=%0d got=%0b want=%0b", cyc, bus.c_drdy, exp_drdy); end
      checks++; if (bus.p_srdy !== m_srdy) begin errors++; $display("FAIL rnd_srdy cyc=%0d got=%0b want=%0b", cyc, bus.p_srdy, m_srdy); end
      if (m_srdy && bus.p_drdy && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.p_data !== e[19:0] || bus.p_cnt !== e[21:20] || bus.p_err !== e[22]) begin
          errors++;
          $display("FAIL rnd_word cyc=%0d got=%05h/%0d/%0b want=%05h/%0d/%0b",
                   cyc, bus.p_data, bus.p_cnt, bus.p_err, e[19:0], e[21:20], e[22]);
        end else begin
          words++;
        end
      end
      acc  = bus.c_srdy && exp_drdy;
      load = 0;
      if (acc && drop) begin
        if (bus.c_ef) drop = 0;
      end else if (acc) begin
        segs.push_back(bus.c_data);
        if (bus.c_ef || segs.size() == NS) begin
          w = '0;
          foreach (segs[k]) w = w | (24'(segs[k]) << (8 * k));
          w[23:20] = '0;
          w[21:20] = 2'(segs.size());
          w[22]    = STRICT && !bus.c_ef;
          exp_q.push_back(w);
          if (STRICT && !bus.c_ef) drop = 1;
          segs.delete();
          load = 1;
        end
      end
      m_srdy = load || (m_srdy && !bus.p_drdy);
      @(posedge clk); #1;
    end
    bus.c_srdy = 0;
    $display("test_random done words=%0d", words);
  endtask

  initial begin
    bus.c_data = '0; bus.c_ef = 0; bus.c_srdy = 0; bus.p_drdy = 0;
    test_reset();
    test_full_word();
    test_short_word();
    test_back_pressure();
    test_overflow();
    test_reset_mid_word();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule
